// File: rtl/ctech_lib_clk_div_pkg.sv
// ---------------------------------------------------------------------------
// ctech_lib_clk_div_pkg
// Shared types and helpers for the ctech programmable clock divider.
//   state_t      : ratio-change handshake states (IDLE, PEND, ACK)
//   MIN_RATIO    : smallest divide ratio the counter can run at
//   clamp_ratio  : maps a requested ratio of 0 or 1 up to MIN_RATIO
// ---------------------------------------------------------------------------
package ctech_lib_clk_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PEND = 2'd1,
      ACK  = 2'd2
   } state_t;

   localparam int unsigned MIN_RATIO = 2;

   // Ratios below two cannot produce a clock with both a high and a low
   // phase, so they are silently raised; every other value passes through.
   function automatic int unsigned clamp_ratio(input int unsigned req);
      return (req < MIN_RATIO) ? MIN_RATIO : req;
   endfunction

endpackage

// File: rtl/ctech_lib_clk_div_ctl.sv
// ---------------------------------------------------------------------------
// ctech_lib_clk_div_ctl
// Four-phase req/ack handshake for changing the divide ratio at run time.
// Holds the shadow ratio until the counter reaches a period boundary.
//   clk, rst_b  : clock, asynchronous active-low reset
//   ratio_req   : ratio-change request from the consumer
//   ratio       : requested ratio, stable while ratio_req is high
//   wrap        : high on edges where a new period may start
//   load        : strobe, shadow is adopted as the active ratio this edge
//   shadow      : clamped ratio waiting to be applied
//   ratio_ack   : request applied, held until ratio_req drops
//   busy        : high while a change is pending
// ---------------------------------------------------------------------------
module ctech_lib_clk_div_ctl
   import ctech_lib_clk_div_pkg::*;
#(
   parameter int DIV_W = 4
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             ratio_req,
   input  logic [DIV_W-1:0] ratio,
   input  logic             wrap,
   output logic             load,
   output logic [DIV_W-1:0] shadow,
   output logic             ratio_ack,
   output logic             busy
);

   state_t state;

   // The shadow is only ever adopted on a period boundary, which is what
   // keeps the divided clock free of runt pulses.
   assign load = (state == PEND) && wrap;

   // Handshake FSM. A request seen in IDLE on a wrap edge only moves to
   // PEND there, so it waits for the following wrap to be applied.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state     <= IDLE;
         shadow    <= '0;
         ratio_ack <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (ratio_req) begin
                  shadow <= DIV_W'(clamp_ratio(32'(ratio)));
                  state  <= PEND;
                  busy   <= 1'b1;
               end
            end
            PEND: begin
               if (wrap) begin
                  state     <= ACK;
                  busy      <= 1'b0;
                  ratio_ack <= 1'b1;
               end
            end
            ACK: begin
               if (!ratio_req) begin
                  state     <= IDLE;
                  ratio_ack <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               ratio_ack <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/ctech_lib_clk_div.sv
// ---------------------------------------------------------------------------
// ctech_lib_clk_div
// Programmable integer clock divider with a glitch-free registered output
// and a one-cycle enable strobe aligned to each divided-clock rising edge.
//   DIV_W       : width of the ratio field (ratio 2 .. 2^DIV_W-1)
//   RESET_RATIO : ratio in effect after reset (>= 2)
//   clk, rst_b  : clock, asynchronous active-low reset
//   ratio_req   : ratio-change request (four-phase, with ratio_ack)
//   ratio       : requested divide value
//   clk_stop    : park request (only with CTECH_LIB_CLK_DIV_STOP_EN)
//   ratio_ack   : request accepted and applied
//   clkout      : divided clock, straight from a flop
//   clken       : pulse on the cycle clkout rises
//   busy        : ratio change pending
// Optional feature macro: CTECH_LIB_CLK_DIV_STOP_EN adds clk_stop, which
// parks the divider at the next period boundary while it is high.
// ---------------------------------------------------------------------------
module ctech_lib_clk_div
   import ctech_lib_clk_div_pkg::*;
#(
   parameter int DIV_W       = 4,
   parameter int RESET_RATIO = 2
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             ratio_req,
   input  logic [DIV_W-1:0] ratio,
`ifdef CTECH_LIB_CLK_DIV_STOP_EN
   input  logic             clk_stop,
`endif
   output logic             ratio_ack,
   output logic             clkout,
   output logic             clken,
   output logic             busy
);

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] cnt_next;
   logic [DIV_W-1:0] n_act;
   logic [DIV_W-1:0] n_next;
   logic [DIV_W-1:0] shadow;
   logic             wrap;
   logic             hold;
   logic             apply_edge;
   logic             load;

   assign wrap = (cnt == n_act - DIV_W'(1));

`ifdef CTECH_LIB_CLK_DIV_STOP_EN
   // Parking happens only on a boundary, so the running period always
   // completes; the counter then sits at N-1 and every held edge is again
   // a boundary, ready to resume straight into a fresh period.
   assign hold = wrap && clk_stop;
`else
   assign hold = 1'b0;
`endif

   // A pending ratio is applied on the edge that starts a new period,
   // which a parked divider does not do until it resumes.
   assign apply_edge = wrap && !hold;

   ctech_lib_clk_div_ctl #(
      .DIV_W (DIV_W)
   ) u_ctl (
      .clk       (clk),
      .rst_b     (rst_b),
      .ratio_req (ratio_req),
      .ratio     (ratio),
      .wrap      (apply_edge),
      .load      (load),
      .shadow    (shadow),
      .ratio_ack (ratio_ack),
      .busy      (busy)
   );

   // Next-state of the period counter and the ratio it runs against. The
   // outputs below are computed from these so a freshly loaded ratio
   // already shapes the first cycle of its own period.
   always_comb begin
      n_next   = load ? shadow : n_act;
      cnt_next = cnt;
      if (hold) begin
         cnt_next = cnt;
      end else if (wrap) begin
         cnt_next = '0;
      end else begin
         cnt_next = cnt + DIV_W'(1);
      end
   end

   // Counter, active ratio and the output flops. The counter resets to
   // N-1 so the very first edge after reset opens a period with clkout
   // and clken both high.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         cnt    <= DIV_W'(RESET_RATIO - 1);
         n_act  <= DIV_W'(RESET_RATIO);
         clkout <= 1'b0;
         clken  <= 1'b0;
      end else begin
         cnt    <= cnt_next;
         n_act  <= n_next;
         clkout <= !hold && (cnt_next < (n_next >> 1));
         clken  <= !hold && (cnt_next == '0);
      end
   end

endmodule

// File: tb/tb_ctech_lib_clk_div.sv
// ---------------------------------------------------------------------------
// tb_ctech_lib_clk_div
// Self-checking bench for ctech_lib_clk_div. A reference model turns each
// period into a queue of expected clkout levels and tracks the handshake
// as a three-state variable; per edge it pushes the expected
// {clkout, clken, ratio_ack, busy} into a scoreboard that a separate
// monitor pops and compares. Define CTECH_LIB_CLK_DIV_STOP_EN to also
// exercise clk_stop.
// ---------------------------------------------------------------------------
module tb_ctech_lib_clk_div;

   localparam int DIV_W       = 4;
   localparam int RESET_RATIO = 2;

   localparam int S_IDLE = 0;
   localparam int S_PEND = 1;
   localparam int S_ACK  = 2;

   logic             clk;
   logic             rst_b;
   logic             ratio_req;
   logic [DIV_W-1:0] ratio;
   logic             clk_stop;
   logic             ratio_ack;
   logic             clkout;
   logic             clken;
   logic             busy;

   int total = 0;
   int bad   = 0;

   logic [3:0] exp_q[$];
   logic       wave[$];
   int         m_n      = RESET_RATIO;
   int         m_shadow = 0;
   int         m_state  = S_IDLE;

   ctech_lib_clk_div #(
      .DIV_W       (DIV_W),
      .RESET_RATIO (RESET_RATIO)
   ) dut (
      .clk       (clk),
      .rst_b     (rst_b),
      .ratio_req (ratio_req),
      .ratio     (ratio),
`ifdef CTECH_LIB_CLK_DIV_STOP_EN
      .clk_stop  (clk_stop),
`endif
      .ratio_ack (ratio_ack),
      .clkout    (clkout),
      .clken     (clken),
      .busy      (busy)
   );

   // Free-running source clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a period is a list of N levels, floor(N/2) high then
   // the rest low; a new list is started (and any pending ratio adopted)
   // only when the previous one is used up.
   initial begin : model
      int   pre;
      logic lvl;
      logic start;
      logic parked;
      forever begin
         @(posedge clk or negedge rst_b);
         if (!rst_b) begin
            m_n      = RESET_RATIO;
            m_shadow = 0;
            m_state  = S_IDLE;
            wave.delete();
         end else begin
            pre    = m_state;
            lvl    = 1'b0;
            start  = 1'b0;
            parked = 1'b0;
            if (wave.size() == 0) begin
               if (clk_stop) begin
                  parked = 1'b1;
               end else begin
                  if (pre == S_PEND) begin
                     m_n     = m_shadow;
                     m_state = S_ACK;
                  end
                  for (int i = 0; i < m_n; i++) wave.push_back(i < m_n / 2);
                  start = 1'b1;
               end
            end
            if (!parked) lvl = wave.pop_front();
            case (pre)
               S_IDLE: begin
                  if (ratio_req) begin
                     m_shadow = (int'(ratio) < 2) ? 2 : int'(ratio);
                     m_state  = S_PEND;
                  end
               end
               S_ACK: begin
                  if (!ratio_req) m_state = S_IDLE;
               end
               default: ;
            endcase
            exp_q.push_back({lvl, start, m_state == S_ACK, m_state == S_PEND});
         end
      end
   end

   // Monitor: one popped expectation per out-of-reset edge, sampled 1 ns
   // after the edge.
   initial begin : monitor
      logic [3:0] got;
      logic [3:0] want;
      forever begin
         @(posedge clk);
         #1;
         if (rst_b) begin
            got = {clkout, clken, ratio_ack, busy};
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL sb_underflow: DUT out %b with no expectation at %0t", got, $time);
            end else begin
               want = exp_q.pop_front();
               checkOutput("sb_clkout_clken_ack_busy", 32'(got), 32'(want));
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Full four-phase ratio change: raise the request, wait (bounded) for
   // the ack, keep the request up a few cycles, then drop it and expect
   // the ack to fall on the very next edge.
   task automatic applyStimulus(input int r, input int hold_cycles);
      int waited;
      ratio     = DIV_W'(r);
      ratio_req = 1'b1;
      waited    = 0;
      while (!ratio_ack && waited < 64) begin
         @(posedge clk);
         #2;
         waited++;
      end
      checkOutput("ack_rise", 32'(ratio_ack), 32'd1);
      idle(hold_cycles);
      ratio_req = 1'b0;
      idle(1);
      checkOutput("ack_release", 32'(ratio_ack), 32'd0);
   endtask

   initial begin : stimulus
      int waited;
      int busy_cycles;
      rst_b     = 1'b0;
      ratio_req = 1'b0;
      ratio     = '0;
      clk_stop  = 1'b0;

      // Reset state, then free run at the reset ratio.
      idle(3);
      checkOutput("reset_outputs", 32'({clkout, clken, ratio_ack, busy}), 32'd0);
      rst_b = 1'b1;
      idle(10);

      // Odd ratio mid-run, then a clamped request of zero.
      applyStimulus(5, 1);
      idle(15);
      applyStimulus(0, 0);
      idle(8);

      // Request sampled exactly on a wrap at N=4: busy for a whole period.
      applyStimulus(4, 0);
      idle(3);
      waited = 0;
      while (!clken && waited < 20) begin
         idle(1);
         waited++;
      end
      checkOutput("clken_seen_n4", 32'(clken), 32'd1);
      idle(3);
      ratio       = DIV_W'(9);
      ratio_req   = 1'b1;
      busy_cycles = 0;
      waited      = 0;
      do begin
         idle(1);
         waited++;
         if (busy) busy_cycles++;
      end while (!ratio_ack && waited < 40);
      checkOutput("defer_busy_cycles", 32'(busy_cycles), 32'd4);
      checkOutput("defer_ack", 32'(ratio_ack), 32'd1);
      ratio_req = 1'b0;
      idle(20);

      // Randomised ratio changes with random spacing and hold times,
      // including back-to-back re-requests right after the ack falls.
      for (int k = 0; k < 10; k++) begin
         idle($urandom_range(0, 6));
         applyStimulus(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
      end
      idle(30);

`ifdef CTECH_LIB_CLK_DIV_STOP_EN
      // Park at N=3 mid-period, stay parked, then resume.
      applyStimulus(3, 0);
      idle(int'($urandom_range(1, 4)));
      clk_stop = 1'b1;
      idle(8);
      clk_stop = 1'b0;
      idle(9);
`endif

      // Asynchronous reset while a ratio of 7 is pending.
      ratio     = DIV_W'(7);
      ratio_req = 1'b1;
      idle(1);
      checkOutput("pend_busy", 32'(busy), 32'd1);
      #1;
      rst_b = 1'b0;
      #1;
      checkOutput("async_reset_outputs", 32'({clkout, clken, ratio_ack, busy}), 32'd0);
      ratio_req = 1'b0;
      idle(2);
      rst_b = 1'b1;
      idle(12);
      checkOutput("post_reset_ack", 32'(ratio_ack), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
